if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_pkg.sv | 27 ++
 rtl/if_stage_if.sv | 25 ++
 rtl/if_stage_imem.sv | 26 ++
 rtl/if_stage.sv | 90 +++++++++
 tb/tb_if_stage.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Holds the instruction memory geometry, the reset/limit addresses,
// the fetch FSM state encoding and the next-PC helper.
package if_pkg;

    localparam int          IMEM_DEPTH  = 1024;
    localparam int          IMEM_ADDR_W = 10;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] PC_LIMIT    = 32'h0000_1000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    // Sequential or branch target, wrapping modulo 2^32. The word offset is
    // turned into a byte offset by <<2; its two top bits fall off the end.
    function automatic logic [31:0] calc_next_pc(input logic [31:0] pc,
                                                 input logic        sel,
                                                 input logic [31:0] immed);
        logic [31:0] offs;
        offs = sel ? (immed << 2) : 32'd0;
        return pc + 32'd4 + offs;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch <-> decode bundle.
//   master : fetch side (drives Instr, Instr_valid, PC, Fault)
//   slave  : decode side (drives PC_LdEn, PC_sel, Immed, Dec_ready)
interface if_stage_if;

    logic        PC_LdEn;
    logic        PC_sel;
    logic [31:0] Immed;
    logic        Dec_ready;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic [31:0] PC;
    logic        Fault;

    modport master (
        input  PC_LdEn, PC_sel, Immed, Dec_ready,
        output Instr, Instr_valid, PC, Fault
    );

    modport slave (
        output PC_LdEn, PC_sel, Immed, Dec_ready,
        input  Instr, Instr_valid, PC, Fault
    );

endinterface

// File: rtl/if_stage_imem.sv
// imem: 1024x32 instruction ROM with synchronous, enabled read.
// Ports: Clk (read clock), en (read enable; dout holds when low),
//        addr (word address), dout (registered read data).
// The array has no write port; its contents come from the memory
// initialisation image of the target flow.
module imem
    import if_pkg::*;
(
    input  logic                   Clk,
    input  logic                   en,
    input  logic [IMEM_ADDR_W-1:0] addr,
    output logic [31:0]            dout
);

    logic [31:0] mem [IMEM_DEPTH];
    logic [31:0] dout_q;

    always_ff @(posedge Clk) begin
        if (en) begin
            dout_q <= mem[addr];
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage.
// Ports: Clk, Reset (synchronous, active-high), bus (if_stage_if.master):
//   in  PC_LdEn, PC_sel, Immed, Dec_ready
//   out Instr, Instr_valid, PC, Fault
// Holds the PC register, the next-PC adder/mux and the BOOT/RUN/HALT FSM.
// The ROM is read with the address the PC is about to take, so the word
// appears together with the new PC and issue is back-to-back.
module if_stage
    import if_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    if_stage_if.master bus
);

    state_e                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            next_pc;
    logic                   adv;
    logic                   rom_en;
    logic [IMEM_ADDR_W-1:0] rom_addr;
    logic [31:0]            rom_dout;

    imem u_imem (
        .Clk  (Clk),
        .en   (rom_en),
        .addr (rom_addr),
        .dout (rom_dout)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state, PC update and ROM read issue
    always_comb begin
        next_pc  = calc_next_pc(pc_q, bus.PC_sel, bus.Immed);
        adv      = bus.PC_LdEn & bus.Dec_ready;
        state_d  = state_q;
        pc_d     = pc_q;
        rom_en   = 1'b0;
        rom_addr = pc_q[IMEM_ADDR_W+1:2];
        case (state_q)
            S_BOOT: begin
                rom_en  = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (adv) begin
                    pc_d = next_pc;
                    // An out-of-range target is latched into PC for
                    // visibility but never fetched.
                    if (next_pc >= PC_LIMIT) begin
                        state_d = S_HALT;
                    end else begin
                        rom_en   = 1'b1;
                        rom_addr = next_pc[IMEM_ADDR_W+1:2];
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
        // A read issued in a reset cycle would only be discarded.
        if (Reset) begin
            rom_en = 1'b0;
        end
    end

    // Outputs: ROM data is only exposed while running, so the unreset
    // ROM register never leaks out during boot or halt.
    always_comb begin
        bus.PC          = pc_q;
        bus.Instr_valid = (state_q == S_RUN);
        bus.Instr       = (state_q == S_RUN) ? rom_dout : 32'd0;
        bus.Fault       = (state_q == S_HALT);
    end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios followed by random traffic,
// checked by a scoreboard against a transaction-level fetch model.
module tb_if_stage;

    logic clk;
    logic rst;

    if_stage_if bus();

    if_stage dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rom_m [1024];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = booting, 1 = running, 2 = halted
    int          m_mode = 0;
    logic [31:0] m_pc   = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, push the outputs
    // expected right after the coming clock edge.
    task automatic step(input logic r, input logic ld, input logic sel,
                        input logic [31:0] imm, input logic rdy);
        exp_t        e;
        logic [31:0] tgt;
        rst           = r;
        bus.PC_LdEn   = ld;
        bus.PC_sel    = sel;
        bus.Immed     = imm;
        bus.Dec_ready = rdy;
        if (r) begin
            m_mode = 0;
            m_pc   = 32'd0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && ld && rdy) begin
            tgt    = m_pc + 32'd4 + (sel ? imm * 32'd4 : 32'd0);
            m_pc   = tgt;
            m_mode = (tgt >= 32'h1000) ? 2 : 1;
        end
        e.pc    = m_pc;
        e.valid = (m_mode == 1);
        e.fault = (m_mode == 2);
        e.instr = (m_mode == 1) ? rom_m[m_pc[11:2]] : 32'd0;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_step(input int rst_odds);
        logic [31:0] imm;
        if ($urandom_range(0, 19) == 0) imm = $urandom;
        else                            imm = 32'($urandom_range(0, 40)) - 32'd20;
        step(($urandom_range(0, rst_odds) == 0),
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) == 0),
             imm,
             ($urandom_range(0, 3) != 0));
    endtask

    // Monitor: one expected record per clock edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc",    bus.PC,                  e.pc);
            check("valid", {31'd0, bus.Instr_valid}, {31'd0, e.valid});
            check("instr", bus.Instr,               e.instr);
            check("fault", {31'd0, bus.Fault},       {31'd0, e.fault});
        end
    end

    initial begin
        rst           = 1'b1;
        bus.PC_LdEn   = 1'b0;
        bus.PC_sel    = 1'b0;
        bus.Immed     = 32'd0;
        bus.Dec_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            rom_m[i] = $urandom;
        end
        rom_m[0] = 32'hE001_0007;
        rom_m[1] = 32'hE002_0005;
        rom_m[2] = 32'hE003_0005;
        for (int i = 0; i < 1024; i++) begin
            dut.u_imem.mem[i] = rom_m[i];
        end
        @(negedge clk);

        // Reset for two cycles, release: boot then first word
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // Sequential 0 -> 4 -> 8
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        // Backward branch from 8 by -3 words lands on 0
        step(0, 1, 1, 32'hFFFF_FFFD, 1);
        // Advance to 4, stall three cycles with PC_LdEn high, then resume
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 32'hFFFF_FFFD, 1);
        // Out-of-range branch from 0 to 0x1004, then ignore inputs
        step(0, 1, 1, 32'h0000_0400, 1);
        for (int i = 0; i < 5; i++) begin
            rand_step(1 << 30);
        end
        step(1, 1, 1, 32'h0000_0001, 1);
        step(0, 1, 0, 0, 1);
        // Reset colliding with an advance at PC=4
        step(0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_step(49);
        end

        @(posedge clk);
        #2;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
